muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage of the MIPS pipeline. It consumes the decoder's `startDiv`/`Sign`/`annul` controls and the `DataToHI`/`DataToLO` source selection. It runs a radix-2 restoring divider or a latency-padded multiplier and stalls the pipeline while busy. It also delivers a one-cycle result strobe with the HI/LO values for the HILO write path.

---
 rtl/muldiv_ctrl_if.sv | 25 ++
 rtl/muldiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Handshake and data bundle between the EX-stage decoder controls and the
// multiply/divide sequencer.
interface muldiv_ctrl_if;
  logic        start_div;
  logic        start_mul;
  logic        sign;
  logic        annul;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        stall;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_zero;

  modport master (
    output start_div, start_mul, sign, annul, opa, opb,
    input  stall, result_valid, hi_out, lo_out, div_zero
  );

  modport slave (
    input  start_div, start_mul, sign, annul, opa, opb,
    output stall, result_valid, hi_out, lo_out, div_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer: radix-2 restoring divider (32 steps)
// and a latency-padded multiplier, with pipeline stall and a one-cycle
// HI/LO result strobe.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_MUL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] opa_raw_q, opa_raw_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        rv_q, rv_d;
  logic        dzo_q, dzo_d;

  logic [32:0] rem_sh;
  logic [31:0] rem_nx, quo_nx, rem_fix, quo_fix;
  logic        busy;

  // One restoring step plus sign fix-up of the step's outcome; the final
  // step's result feeds the output registers directly so DONE is not delayed.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    quo_nx = {quo_q[30:0], 1'b0};
    rem_nx = rem_sh[31:0];
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_nx    = 32'(rem_sh - {1'b0, dvs_q});
      quo_nx[0] = 1'b1;
    end
    quo_fix = qneg_q ? 32'(-quo_nx) : quo_nx;
    rem_fix = rneg_q ? 32'(-rem_nx) : rem_nx;
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    opa_raw_d = opa_raw_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dzo_d     = dzo_q;
    rv_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.annul) begin
          if (bus.start_div) begin
            state_d   = S_DIV;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = (bus.sign && bus.opa[31]) ? 32'(-bus.opa) : bus.opa;
            dvs_d     = (bus.sign && bus.opb[31]) ? 32'(-bus.opb) : bus.opb;
            opa_raw_d = bus.opa;
            qneg_d    = bus.sign & (bus.opa[31] ^ bus.opb[31]);
            rneg_d    = bus.sign & bus.opa[31];
            dz_d      = (bus.opb == '0);
          end else if (bus.start_mul) begin
            state_d = S_MUL;
            cnt_d   = '0;
            prod_d  = bus.sign ? ({{32{bus.opa[31]}}, bus.opa} * {{32{bus.opb[31]}}, bus.opb})
                               : ({32'b0, bus.opa} * {32'b0, bus.opb});
          end
        end
      end
      S_DIV: begin
        if (bus.annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'd31) begin
            state_d = S_DONE;
            rv_d    = 1'b1;
            dzo_d   = dz_q;
            if (dz_q) begin
              hi_d = opa_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
        end
      end
      S_MUL: begin
        if (bus.annul) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'(MUL_CYCLES - 1)) begin
            state_d = S_DONE;
            rv_d    = 1'b1;
            dzo_d   = 1'b0;
            hi_d    = prod_q[63:32];
            lo_d    = prod_q[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      opa_raw_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rv_q      <= 1'b0;
      dzo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      opa_raw_q <= opa_raw_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      prod_q    <= prod_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rv_q      <= rv_d;
      dzo_q     <= dzo_d;
    end
  end

  // Stall is combinational so annul releases the pipeline in the same cycle.
  always_comb begin
    busy = (state_q == S_DIV) || (state_q == S_MUL) ||
           ((state_q == S_IDLE) && (bus.start_div || bus.start_mul));
    bus.stall = busy & ~bus.annul & ~rst;
  end

  assign bus.result_valid = rv_q;
  assign bus.hi_out       = hi_q;
  assign bus.lo_out       = lo_q;
  assign bus.div_zero     = dzo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes reference results,
// an independent monitor pops them on every result_valid.
module tb_muldiv_ctrl;
  localparam int MC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus ();
  muldiv_ctrl #(.MUL_CYCLES(MC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit is_div, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e = '0;
    if (is_div) begin
      if (b == 0) begin
        e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
      end else if (sgn) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 0;
        end else begin
          e.lo = 32'($signed(a) / $signed(b));
          e.hi = 32'($signed(a) % $signed(b));
        end
      end else begin
        e.lo = a / b; e.hi = a % b;
      end
    end else begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32]; e.lo = p[31:0];
    end
    return e;
  endfunction

  // Monitor: every result strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: got result_valid=1 expected none at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("hi_out", bus.hi_out, e.hi);
        check("lo_out", bus.lo_out, e.lo);
        check("div_zero", bus.div_zero, e.dz);
      end
    end
  end

  task automatic run_op(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit hold_ok;
    lat = is_div ? 33 : MC + 1;
    hold_ok = 1'b1;
    @(negedge clk);
    bus.start_div = is_div; bus.start_mul = !is_div;
    bus.sign = sgn; bus.opa = a; bus.opb = b;
    #1 check("stall_start", bus.stall, 1);
    sb.push_back(model(is_div, sgn, a, b));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start_div = 0; bus.start_mul = 0;
        bus.opa = $urandom; bus.opb = $urandom;
      end
      #1;
      if (k < lat - 1 && (bus.stall !== 1'b1 || bus.result_valid !== 1'b0)) hold_ok = 1'b0;
      if (k == lat - 1) begin
        check("stall_last_busy", bus.stall, 1);
        check("valid_early", bus.result_valid, 0);
      end
      if (k == lat) begin
        check("stall_done", bus.stall, 0);
        check("valid_latency", bus.result_valid, 1);
      end
    end
    check("stall_hold", hold_ok, 1);
    @(negedge clk);
    #1 check("valid_one_cycle", bus.result_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          d, s;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.start_div = 1; bus.start_mul = 0; bus.sign = 0; bus.annul = 0;
    bus.opa = 100; bus.opb = 7;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", bus.stall, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_hi", bus.hi_out, 0);
    check("rst_lo", bus.lo_out, 0);
    check("rst_dz", bus.div_zero, 0);
    bus.start_div = 0;
    rst = 1'b0;

    // Directed cases
    run_op(1, 0, 100, 7);
    run_op(1, 1, 32'hFFFF_FFF9, 2);
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(0, 1, 32'hFFFF_FFFF, 2);
    run_op(0, 0, 32'hFFFF_FFFF, 2);
    run_op(1, 0, 5, 0);
    run_op(1, 1, 32'hFFFF_FFF9, 0);
    run_op(1, 0, 100, 7);

    // Annul mid-divide: no result, outputs hold 2/14
    @(negedge clk);
    bus.start_div = 1; bus.sign = 1; bus.opa = 50; bus.opb = 3;
    #1 check("annul_start_stall", bus.stall, 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_div = 0;
    end
    bus.annul = 1;
    #1 check("annul_stall_drop", bus.stall, 0);
    @(negedge clk);
    bus.annul = 0;
    #1;
    check("annul_idle_stall", bus.stall, 0);
    check("annul_no_valid", bus.result_valid, 0);
    repeat (40) @(negedge clk);
    check("annul_hi_hold", bus.hi_out, 2);
    check("annul_lo_hold", bus.lo_out, 14);

    // Start together with annul in IDLE: ignored
    @(negedge clk);
    bus.start_div = 1; bus.annul = 1; bus.opa = 9; bus.opb = 3;
    #1 check("annul_start_stall", bus.stall, 0);
    @(negedge clk);
    bus.start_div = 0; bus.annul = 0;
    #1 check("annul_start_idle", bus.stall, 0);
    repeat (36) @(negedge clk);
    check("annul_start_lo", bus.lo_out, 14);

    // Reset mid-divide
    @(negedge clk);
    bus.start_div = 1; bus.sign = 0; bus.opa = 1000; bus.opb = 7;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_div = 0;
    end
    rst = 1'b1;
    #1;
    check("midrst_stall", bus.stall, 0);
    check("midrst_hi", bus.hi_out, 0);
    check("midrst_lo", bus.lo_out, 0);
    check("midrst_valid", bus.result_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_idle", bus.stall, 0);
    run_op(1, 0, 9, 3);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run_op(d, s, a, b);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
